// File: rtl/alu_issue_stage_pkg.sv
// Shared types and RV32I encoding constants for the ALU issue stage.
// Covers ALU op codes, operand-B select, opcode/funct fields and immediate extraction.
package alu_issue_stage_pkg;

   typedef enum logic [3:0] {
      ALU_AND     = 4'b0000,
      ALU_OR      = 4'b0001,
      ALU_ADD     = 4'b0010,
      ALU_SUB     = 4'b0110,
      ALU_INVALID = 4'b1111
   } alu_op_t;

   typedef enum logic {
      SRC2_RS2 = 1'b0,
      SRC2_IMM = 1'b1
   } src2_sel_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_BNE     = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   function automatic logic [11:0] imm_i(input logic [31:0] instr);
      return instr[31:20];
   endfunction

   function automatic logic [11:0] imm_s(input logic [31:0] instr);
      return {instr[31:25], instr[11:7]};
   endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: instruction/register-data input handshake and the ID/EX payload.
// master drives instructions and consumes the payload; slave is the issue stage.
interface alu_issue_stage_if
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32
);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            flush;

   logic            out_valid;
   logic            out_ready;
   alu_op_t         aluop;
   logic [XLEN-1:0] data1;
   logic [XLEN-1:0] data2;
   logic [XLEN-1:0] store_data;
   logic [4:0]      rd;
   logic            reg_write;
   logic            mem_read;
   logic            mem_write;
   logic            branch;
   logic            branch_ne;
   logic            illegal;

   modport master (
      output in_valid, instr, rs1_data, rs2_data, flush, out_ready,
      input  in_ready, out_valid, aluop, data1, data2, store_data, rd,
             reg_write, mem_read, mem_write, branch, branch_ne, illegal
   );

   modport slave (
      input  in_valid, instr, rs1_data, rs2_data, flush, out_ready,
      output in_ready, out_valid, aluop, data1, data2, store_data, rd,
             reg_write, mem_read, mem_write, branch, branch_ne, illegal
   );

endinterface

// File: rtl/alu_issue_stage_decode.sv
// Combinational RV32I ALU-subset decoder: ALU op, sign-extended immediate, operand select and control flags.
// Any encoding outside the subset reports illegal with op 4'b1111 and every side-effect flag cleared.
module alu_decode
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32
)
(
   input  logic [31:0]     instr,
   output alu_op_t         aluop,
   output logic [XLEN-1:0] imm,
   output src2_sel_t       src2,
   output logic            reg_write,
   output logic            mem_read,
   output logic            mem_write,
   output logic            branch,
   output logic            branch_ne,
   output logic            illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [11:0] imm12;
   logic        unused_rs1_field;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign unused_rs1_field = ^instr[19:15];

   always_comb begin
      aluop     = ALU_INVALID;
      imm12     = imm_i(instr);
      src2      = SRC2_RS2;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      branch_ne = 1'b0;
      illegal   = 1'b1;

      case (opcode)
         OP_R: begin
            if (funct7 == F7_BASE) begin
               case (funct3)
                  F3_ADD_SUB: aluop = ALU_ADD;
                  F3_AND:     aluop = ALU_AND;
                  F3_OR:      aluop = ALU_OR;
                  default:    aluop = ALU_INVALID;
               endcase
            end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
               aluop = ALU_SUB;
            end
            illegal   = (aluop == ALU_INVALID);
            reg_write = !illegal;
         end

         OP_IMM: begin
            // funct7 bits belong to the immediate here, so they are not checked
            case (funct3)
               F3_ADD_SUB: aluop = ALU_ADD;
               F3_AND:     aluop = ALU_AND;
               F3_OR:      aluop = ALU_OR;
               default:    aluop = ALU_INVALID;
            endcase
            illegal   = (aluop == ALU_INVALID);
            reg_write = !illegal;
            src2      = SRC2_IMM;
         end

         OP_LOAD: begin
            if (funct3 == F3_WORD) begin
               aluop     = ALU_ADD;
               src2      = SRC2_IMM;
               mem_read  = 1'b1;
               reg_write = 1'b1;
               illegal   = 1'b0;
            end
         end

         OP_STORE: begin
            if (funct3 == F3_WORD) begin
               aluop     = ALU_ADD;
               imm12     = imm_s(instr);
               src2      = SRC2_IMM;
               mem_write = 1'b1;
               illegal   = 1'b0;
            end
         end

         OP_BRANCH: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
               aluop     = ALU_SUB;
               branch    = 1'b1;
               branch_ne = funct3[0];
               illegal   = 1'b0;
            end
         end

         default: begin
            aluop = ALU_INVALID;
         end
      endcase
   end

   assign imm = {{(XLEN-12){imm12[11]}}, imm12};

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes the ALU subset and holds operands behind a valid/ready handshake.
// Flush kills both the held entry and any same-cycle capture; reset clears the payload immediately.
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32
)
(
   input  logic             clk,
   input  logic             rst,
   alu_issue_stage_if.slave bus
);

   alu_op_t         dec_aluop;
   logic [XLEN-1:0] dec_imm;
   src2_sel_t       dec_src2;
   logic            dec_reg_write;
   logic            dec_mem_read;
   logic            dec_mem_write;
   logic            dec_branch;
   logic            dec_branch_ne;
   logic            dec_illegal;

   logic            capture;
   logic [XLEN-1:0] operand_b;

   alu_decode #(.XLEN(XLEN)) u_decode (
      .instr     (bus.instr),
      .aluop     (dec_aluop),
      .imm       (dec_imm),
      .src2      (dec_src2),
      .reg_write (dec_reg_write),
      .mem_read  (dec_mem_read),
      .mem_write (dec_mem_write),
      .branch    (dec_branch),
      .branch_ne (dec_branch_ne),
      .illegal   (dec_illegal)
   );

   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign capture      = bus.in_valid && bus.in_ready && !bus.flush;
   assign operand_b    = (dec_src2 == SRC2_IMM) ? dec_imm : bus.rs2_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
      end else if (capture) begin
         bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.aluop      <= ALU_AND;
         bus.data1      <= '0;
         bus.data2      <= '0;
         bus.store_data <= '0;
         bus.rd         <= '0;
         bus.reg_write  <= 1'b0;
         bus.mem_read   <= 1'b0;
         bus.mem_write  <= 1'b0;
         bus.branch     <= 1'b0;
         bus.branch_ne  <= 1'b0;
         bus.illegal    <= 1'b0;
      end else if (capture) begin
         bus.aluop      <= dec_aluop;
         bus.data1      <= bus.rs1_data;
         bus.data2      <= operand_b;
         bus.store_data <= bus.rs2_data;
         bus.rd         <= bus.instr[11:7];
         bus.reg_write  <= dec_reg_write;
         bus.mem_read   <= dec_mem_read;
         bus.mem_write  <= dec_mem_write;
         bus.branch     <= dec_branch;
         bus.branch_ne  <= dec_branch_ne;
         bus.illegal    <= dec_illegal;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed instruction steps then randomized traffic.
// Expected payloads come from a field-level RV32I decode model and a one-deep entry queue.
module tb_alu_issue_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_issue_stage_if #(.XLEN(32)) bus ();

   alu_issue_stage #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0]  aluop;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        bne;
      logic        ill;
   } exp_t;

   exp_t        q[$];
   int unsigned checks = 0;
   int unsigned passes = 0;

   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      exp_t       e;
      int         imm_i;
      int         imm_s;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op    = ins[6:0];
      f3    = ins[14:12];
      f7    = ins[31:25];
      imm_i = $signed(ins[31:20]);
      imm_s = $signed({ins[31:25], ins[11:7]});
      e.aluop = 4'hF;
      e.d1 = a;  e.d2 = b;  e.sd = b;  e.rd = ins[11:7];
      e.rw = 0;  e.mr = 0;  e.mw = 0;  e.br = 0;  e.bne = 0;
      case (op)
         7'h33: begin
            if (f7 == 7'h00 && f3 == 3'd0)      e.aluop = 4'd2;
            else if (f7 == 7'h20 && f3 == 3'd0) e.aluop = 4'd6;
            else if (f7 == 7'h00 && f3 == 3'd7) e.aluop = 4'd0;
            else if (f7 == 7'h00 && f3 == 3'd6) e.aluop = 4'd1;
            e.rw = (e.aluop != 4'hF);
         end
         7'h13: begin
            e.d2 = imm_i;
            if (f3 == 3'd0)      e.aluop = 4'd2;
            else if (f3 == 3'd7) e.aluop = 4'd0;
            else if (f3 == 3'd6) e.aluop = 4'd1;
            e.rw = (e.aluop != 4'hF);
         end
         7'h03: if (f3 == 3'd2) begin
            e.aluop = 4'd2;  e.d2 = imm_i;  e.mr = 1;  e.rw = 1;
         end
         7'h23: if (f3 == 3'd2) begin
            e.aluop = 4'd2;  e.d2 = imm_s;  e.mw = 1;
         end
         7'h63: if (f3 == 3'd0 || f3 == 3'd1) begin
            e.aluop = 4'd6;  e.br = 1;  e.bne = (f3 == 3'd1);
         end
         default: e.aluop = 4'hF;
      endcase
      e.ill = (e.aluop == 4'hF);
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 6))
         0: begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 2)) 0: w[31:25] = 7'h00; 1: w[31:25] = 7'h20; default: ; endcase
            case ($urandom_range(0, 3)) 0: w[14:12] = 3'd0; 1: w[14:12] = 3'd7; 2: w[14:12] = 3'd6; default: ; endcase
         end
         1: w[6:0] = 7'h13;
         2: begin w[6:0] = 7'h03; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd2; end
         3: begin w[6:0] = 7'h23; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd2; end
         4: begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(0, 2)); end
         5: w[6:0] = 7'h33;
         default: ;
      endcase
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_outputs();
      exp_t e;
      check("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
         e = q[0];
         check("aluop", bus.aluop, e.aluop);
         check("rd", bus.rd, e.rd);
         check("reg_write", bus.reg_write, e.rw);
         check("mem_read", bus.mem_read, e.mr);
         check("mem_write", bus.mem_write, e.mw);
         check("branch", bus.branch, e.br);
         check("illegal", bus.illegal, e.ill);
         if (!e.ill) begin
            check("data1", bus.data1, e.d1);
            check("data2", bus.data2, e.d2);
         end
         if (e.br) check("branch_ne", bus.branch_ne, e.bne);
         if (e.mw) check("store_data", bus.store_data, e.sd);
      end
   endtask

   // Called just after a rising edge; returns just after the next one.
   task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic fl, input logic ordy);
      logic rdy;
      bus.in_valid  = iv;
      bus.instr     = ins;
      bus.rs1_data  = a;
      bus.rs2_data  = b;
      bus.flush     = fl;
      bus.out_ready = ordy;
      #1;
      rdy = (q.size() == 0) || ordy;
      check("in_ready", bus.in_ready, rdy);
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (q.size() != 0 && ordy) void'(q.pop_front());
         if (iv && rdy) q.push_back(ref_decode(ins, a, b));
      end
      #1;
      check_outputs();
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.instr     = '0;
      bus.rs1_data  = '0;
      bus.rs2_data  = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_aluop", bus.aluop, 4'b0000);
      check("rst_data1", bus.data1, 32'h0);
      check("rst_data2", bus.data2, 32'h0);
      check("rst_store_data", bus.store_data, 32'h0);
      check("rst_rd", bus.rd, 5'd0);
      check("rst_flags", {bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.branch_ne, bus.illegal}, 6'b0);

      cycle(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b0, 1'b1);
      check("add_aluop", bus.aluop, 4'b0010);
      check("add_data1", bus.data1, 32'd5);
      check("add_data2", bus.data2, 32'd7);
      check("add_rd", bus.rd, 5'd3);

      cycle(1'b1, 32'h402081B3, 32'd5, 32'd7, 1'b0, 1'b1);
      check("sub_aluop", bus.aluop, 4'b0110);
      cycle(1'b1, 32'hFFF00293, 32'd0, 32'd9, 1'b0, 1'b1);
      check("addi_data2", bus.data2, 32'hFFFFFFFF);
      check("addi_rd", bus.rd, 5'd5);

      cycle(1'b1, 32'h0020A423, 32'h100, 32'hAB, 1'b0, 1'b1);
      check("sw_data2", bus.data2, 32'd8);
      check("sw_store_data", bus.store_data, 32'hAB);
      check("sw_flags", {bus.mem_write, bus.reg_write}, 2'b10);

      cycle(1'b1, 32'h00208063, 32'd3, 32'd3, 1'b0, 1'b1);
      check("beq_flags", {bus.branch, bus.branch_ne}, 2'b10);
      cycle(1'b1, 32'hFFFFFFFF, 32'd1, 32'd2, 1'b0, 1'b1);
      check("ill_aluop", bus.aluop, 4'b1111);
      check("ill_valid", {bus.out_valid, bus.illegal}, 2'b11);

      // Backpressure: hold for three cycles, then back-to-back replacement.
      cycle(1'b1, 32'h002081B3, 32'd1, 32'd2, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h402081B3, 32'd9, 32'd9, 1'b0, 1'b0);
      check("hold_data1", bus.data1, 32'd1);
      cycle(1'b1, 32'hFFF00293, 32'd4, 32'd0, 1'b0, 1'b1);
      check("b2b_data1", {31'd0, bus.out_valid} + bus.data1, 32'd5);

      cycle(1'b1, 32'h002081B3, 32'd6, 32'd6, 1'b1, 1'b1);
      check("flush_valid", bus.out_valid, 1'b0);

      // Asynchronous reset in the middle of a held entry.
      cycle(1'b1, 32'h002081B3, 32'd11, 32'd22, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", bus.out_valid, 1'b0);
      check("arst_aluop", bus.aluop, 4'b0000);
      check("arst_data1", bus.data1, 32'h0);
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;

      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom,
               $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue stage that drives the ALU's data1, data2 and aluop operands. It takes a fetched RV32I instruction plus the register-file read data and decodes the ALU subset. It registers the ID/EX payload behind a valid/ready handshake with stall and flush, so the execute stage and ALU see stable, registered operands.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  instruction and register data valid
in_ready  output  1  stage can accept this cycle
instr  input  32  raw instruction word
rs1_data  input  XLEN  register-file read port 1
rs2_data  input  XLEN  register-file read port 2
flush  input  1  synchronous kill of held and incoming entry
out_valid  output  1  payload valid toward EX
out_ready  input  1  EX accepts payload
aluop  output  4  alu_op_t to the ALU
data1  output  XLEN  ALU operand A
data2  output  XLEN  ALU operand B
store_data  output  XLEN  rs2 value for stores
rd  output  5  destination register
reg_write  output  1  writeback enable
mem_read  output  1  load
mem_write  output  1  store
branch  output  1  conditional branch
branch_ne  output  1  branch on not-equal (bne); 0 means beq
illegal  output  1  unsupported encoding

Behaviour:
- Reset (async, rst=1): out_valid=0, aluop=ALU_AND (4'b0000), data1/data2/store_data=0, rd=0, all flags=0. Effect is immediate; in-flight entry is dropped.
- Handshake: in_ready = !out_valid || out_ready (combinational).
  - Capture when in_valid && in_ready; out_valid=1 next cycle; latency 1 cycle.
  - If out_ready && out_valid && !in_valid, out_valid=0 next cycle.
  - Payload holds unchanged while out_valid && !out_ready.
- Flush: next cycle out_valid=0. Flush beats a same-cycle capture, and in_ready still reads as computed. Payload registers are don't-care after flush.
- Decode, registered on capture:
  - R-type (0110011): data1=rs1, data2=rs2, reg_write=1.
    - funct3 000 with funct7 0000000 gives ALU_ADD; with funct7 0100000 gives ALU_SUB.
    - funct3 111 with funct7 0 gives ALU_AND; funct3 110 with funct7 0 gives ALU_OR.
  - I-ALU (0010011): data2 = sign-extended instr[31:20], reg_write=1. funct3 000 gives ADD, 111 gives AND, 110 gives OR.
  - Load (0000011, funct3 010): ALU_ADD, data2 = sign-extended I-imm, mem_read=1, reg_write=1.
  - Store (0100011, funct3 010): ALU_ADD, data2 = sign-extended {instr[31:25],instr[11:7]}, store_data=rs2, mem_write=1, reg_write=0.
  - Branch (1100011): funct3 000 (beq) or 001 (bne) gives ALU_SUB, data1=rs1, data2=rs2, branch=1, branch_ne=funct3[0], reg_write=0.
  - All other encodings: illegal=1, aluop=4'b1111, reg_write=mem_read=mem_write=branch=0. out_valid still asserts so EX can trap.
- rd = instr[11:7] always captured. Writes to rd=0 keep reg_write as decoded; the regfile ignores x0.
- Immediates are 12-bit, sign-extended to XLEN. No arithmetic is performed in this block.

Decomposition:
- Shared package: alu_op_t (4-bit enum: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, invalid code 1111).
- Also in the package: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH) and funct3/funct7 constants.
- One combinational sub-module, alu_decode: instr in, aluop/immediate/flags out. This block wraps it with the handshake register.

Test Plan:
1. add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, in_valid=1, out_ready=1 -> next cycle out_valid=1, aluop=0010, data1=5, data2=7, rd=3, reg_write=1.
2. sub (0x402081B3) -> aluop=0110. addi x5,x0,-1 (0xFFF00293), rs1=0 -> aluop=0010, data2=FFFFFFFF, rd=5.
3. sw x2,8(x1) (0x0020A423), rs1=0x100, rs2=0xAB -> aluop=0010, data1=0x100, data2=8, store_data=0xAB, mem_write=1, reg_write=0.
4. beq (0x00208063), rs1=rs2=3 -> aluop=0110, branch=1, branch_ne=0. Instr 0xFFFFFFFF -> illegal=1, aluop=1111, out_valid=1.
5. Backpressure: out_ready=0 for 3 cycles after a capture -> in_ready=0, payload and out_valid stable. Raise out_ready with a new in_valid -> back-to-back capture, no bubble.
6. Flush with in_valid=1 -> out_valid=0 next cycle. Assert rst mid-hold -> out_valid=0 and aluop=0000 before the next clk edge.
